// File: rtl/instr_encoder_if.sv
// Request, instruction-memory write and session-status signals of the MIPS instruction encoder.
// The encoder connects through the slave modport; the loader or bench driving it uses master.
interface instr_encoder_if #(
  parameter int CNT_W = 16
);
  logic             start_i;
  logic [31:0]      base_addr_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [3:0]       req_op_i;
  logic [4:0]       req_rs_i;
  logic [4:0]       req_rt_i;
  logic [4:0]       req_rd_i;
  logic [15:0]      req_imm_i;
  logic [25:0]      req_target_i;
  logic             req_last_i;
  logic             mem_we_o;
  logic [31:0]      mem_addr_o;
  logic [31:0]      mem_data_o;
  logic             mem_ack_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
  logic [CNT_W-1:0] count_o;

  modport slave (
    input  start_i, base_addr_i, req_valid_i, req_op_i, req_rs_i, req_rt_i,
           req_rd_i, req_imm_i, req_target_i, req_last_i, mem_ack_i,
    output req_ready_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o,
           err_o, count_o
  );

  modport master (
    output start_i, base_addr_i, req_valid_i, req_op_i, req_rs_i, req_rt_i,
           req_rd_i, req_imm_i, req_target_i, req_last_i, mem_ack_i,
    input  req_ready_o, mem_we_o, mem_addr_o, mem_data_o, busy_o, done_o,
           err_o, count_o
  );
endinterface

// File: rtl/instr_encoder.sv
// Boot loader that turns field-level MIPS instruction requests into machine words
// and writes them sequentially into instruction memory over a write/ack port.
//
// state | meaning
// IDLE  | waiting for start_i
// RUN   | ready for a request
// WRITE | holding a write until mem_ack_i
// DONE  | one-cycle done_o pulse, then IDLE
module instr_encoder #(
  parameter int MAX_WORDS = 256,
  parameter int CNT_W     = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, WRITE, DONE} state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t      state, state_nxt;
  logic        last_q;
  logic [31:0] enc_word;
  logic        legal;
  logic        accept;
  logic        store;

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (bus.req_op_i)
      4'd0:  enc_word = {6'b000000, bus.req_rs_i, bus.req_rt_i, bus.req_rd_i, 5'b0, 6'b100000};
      4'd1:  enc_word = {6'b000000, bus.req_rs_i, bus.req_rt_i, bus.req_rd_i, 5'b0, 6'b100010};
      4'd2:  enc_word = {6'b000000, bus.req_rs_i, bus.req_rt_i, bus.req_rd_i, 5'b0, 6'b100100};
      4'd3:  enc_word = {6'b000000, bus.req_rs_i, bus.req_rt_i, bus.req_rd_i, 5'b0, 6'b100101};
      4'd4:  enc_word = {6'b000000, bus.req_rs_i, bus.req_rt_i, bus.req_rd_i, 5'b0, 6'b101010};
      4'd5:  enc_word = {6'b000000, bus.req_rs_i, 15'b0, 6'b001000};
      4'd6:  enc_word = {6'b001000, bus.req_rs_i, bus.req_rt_i, bus.req_imm_i};
      4'd7:  enc_word = {6'b001010, bus.req_rs_i, bus.req_rt_i, bus.req_imm_i};
      4'd8:  enc_word = {6'b000100, bus.req_rs_i, bus.req_rt_i, bus.req_imm_i};
      4'd9:  enc_word = {6'b100011, bus.req_rs_i, bus.req_rt_i, bus.req_imm_i};
      4'd10: enc_word = {6'b101011, bus.req_rs_i, bus.req_rt_i, bus.req_imm_i};
      4'd11: enc_word = {6'b000010, bus.req_target_i};
      4'd12: enc_word = {6'b000011, bus.req_target_i};
      default: legal = 1'b0;
    endcase
  end

  assign accept = (state == RUN) && bus.req_valid_i;
  assign store  = accept && legal && (bus.count_o < MAX_CNT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.req_ready_o = 1'b0;
    bus.busy_o      = 1'b1;
    bus.done_o      = 1'b0;
    case (state)
      IDLE: begin
        bus.busy_o = 1'b0;
        if (bus.start_i) state_nxt = RUN;
      end
      RUN: begin
        bus.req_ready_o = 1'b1;
        if (store)                         state_nxt = WRITE;
        else if (accept && bus.req_last_i) state_nxt = DONE;
      end
      WRITE: begin
        if (bus.mem_ack_i) state_nxt = last_q ? DONE : RUN;
      end
      DONE: begin
        bus.done_o = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Dropped requests (illegal op or full session) only raise the sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bus.mem_we_o   <= 1'b0;
      bus.mem_addr_o <= '0;
      bus.mem_data_o <= '0;
      bus.count_o    <= '0;
      bus.err_o      <= 1'b0;
      last_q         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start_i) begin
            bus.mem_addr_o <= bus.base_addr_i;
            bus.count_o    <= '0;
            bus.err_o      <= 1'b0;
          end
        end
        RUN: begin
          if (store) begin
            bus.mem_data_o <= enc_word;
            bus.mem_we_o   <= 1'b1;
            last_q         <= bus.req_last_i;
          end else if (accept) begin
            bus.err_o <= 1'b1;
          end
        end
        WRITE: begin
          if (bus.mem_ack_i) begin
            bus.mem_we_o   <= 1'b0;
            bus.mem_addr_o <= bus.mem_addr_o + 32'd4;
            bus.count_o    <= bus.count_o + CNT_ONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
